// File: rtl/nature2grey_wptr.sv
// Write-side pointer generator for a dual-clock FIFO.
// Holds the binary/gray write pointers and derives full, almost_full and fill level from the synchronised read pointer.
module nature2grey_wptr #(
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W:0]   rd_ptr_grey_sync,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_ptr_bin,
    output logic [ADDR_W:0]   wr_ptr_grey,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level
);

    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'((2 ** ADDR_W) - AF_MARGIN);

    logic [ADDR_W:0] rd_bin;
    logic [ADDR_W:0] bin_next;
    logic [ADDR_W:0] grey_next;
    logic [ADDR_W:0] full_match;
    logic [ADDR_W:0] level_next;

    assign wr_ack  = rst_n & wr_req & ~full;
    assign wr_addr = wr_ptr_bin[ADDR_W-1:0];

    // Each binary bit is the XOR of its gray bit and every gray bit above it.
    always_comb begin
        rd_bin = '0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            rd_bin[i] = ^(rd_ptr_grey_sync >> i);
        end
    end

    assign bin_next   = wr_ptr_bin + (ADDR_W+1)'(wr_ack);
    assign grey_next  = bin_next ^ (bin_next >> 1);
    assign full_match = {~rd_ptr_grey_sync[ADDR_W:ADDR_W-1], rd_ptr_grey_sync[ADDR_W-2:0]};
    assign level_next = bin_next - rd_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_bin  <= '0;
            wr_ptr_grey <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            wr_ptr_bin  <= bin_next;
            wr_ptr_grey <= grey_next;
            full        <= (grey_next == full_match);
            almost_full <= (level_next >= AF_THRESH);
            wr_level    <= level_next;
        end
    end

endmodule

// File: tb/tb_nature2grey_wptr.sv
// Directed, table-driven bench for nature2grey_wptr with ADDR_W=4, AF_MARGIN=2.
module tb_nature2grey_wptr;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic [4:0] rd_ptr_grey_sync;
    logic       wr_ack;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_bin;
    logic [4:0] wr_ptr_grey;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;

    int checks   = 0;
    int failures = 0;

    nature2grey_wptr #(.ADDR_W(4), .AF_MARGIN(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_req           (wr_req),
        .rd_ptr_grey_sync (rd_ptr_grey_sync),
        .wr_ack           (wr_ack),
        .wr_addr          (wr_addr),
        .wr_ptr_bin       (wr_ptr_bin),
        .wr_ptr_grey      (wr_ptr_grey),
        .full             (full),
        .almost_full      (almost_full),
        .wr_level         (wr_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       wr_req;
        logic [4:0] rd;
        logic       ack;
        logic [4:0] bin;
        logic [4:0] grey;
        logic       full;
        logic       af;
        logic [4:0] lvl;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [4:0] rd, input logic a,
                       input logic [4:0] b, input logic [4:0] g, input logic f,
                       input logic af, input logic [4:0] l);
        vec_t v;
        v.rst_n = r; v.wr_req = w; v.rd = rd; v.ack = a;
        v.bin = b; v.grey = g; v.full = f; v.af = af; v.lvl = l;
        vq.push_back(v);
    endtask

    // Inputs change just after a posedge; ack is checked before the next edge, state just after it.
    task automatic apply(input vec_t v, input string tag);
        rst_n            = v.rst_n;
        wr_req           = v.wr_req;
        rd_ptr_grey_sync = v.rd;
        #1;
        chk({tag, ".wr_ack"}, 32'(wr_ack), 32'(v.ack));
        @(posedge clk);
        #1;
        chk({tag, ".wr_ptr_bin"}, 32'(wr_ptr_bin), 32'(v.bin));
        chk({tag, ".wr_ptr_grey"}, 32'(wr_ptr_grey), 32'(v.grey));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(v.bin[3:0]));
        chk({tag, ".full"}, 32'(full), 32'(v.full));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(v.af));
        chk({tag, ".wr_level"}, 32'(wr_level), 32'(v.lvl));
    endtask

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [4:0] g_tab [17] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
                               5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08, 5'h18};

    initial begin
        vec_t v;
        rst_n = 1'b0;
        wr_req = 1'b1;
        rd_ptr_grey_sync = 5'h00;

        // Reset with wr_req held high
        add(0, 1, 5'h00, 0, 5'h00, 5'h00, 0, 0, 5'd0);
        add(0, 1, 5'h00, 0, 5'h00, 5'h00, 0, 0, 5'd0);
        // Fill from empty: 16 accepted writes
        for (int k = 1; k <= 16; k++)
            add(1, 1, 5'h00, 1, 5'(k), g_tab[k], (k == 16), (k >= 14), 5'(k));
        // Writes while full are refused and the pointer holds
        for (int k = 0; k < 5; k++)
            add(1, 1, 5'h00, 0, 5'h10, 5'h18, 1, 1, 5'd16);
        // Read pointer advances to 1: full drops, level 15
        add(1, 0, 5'h01, 0, 5'h10, 5'h18, 0, 1, 5'd15);
        // Next write accepted and fills again
        add(1, 1, 5'h01, 1, 5'h11, 5'h19, 1, 1, 5'd16);
        // Read advances to 2 without a write
        add(1, 0, 5'h03, 0, 5'h11, 5'h19, 0, 1, 5'd15);
        // Read advances to 3 together with an accepted write: level stays 15
        add(1, 1, 5'h02, 1, 5'h12, 5'h1B, 0, 1, 5'd15);

        for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

        // Wrap: keep FIFO nearly empty while stepping the pointer to 0x1F, then across zero
        v.rst_n = 0; v.wr_req = 1; v.rd = 5'h00; v.ack = 0;
        v.bin = 5'h00; v.grey = 5'h00; v.full = 0; v.af = 0; v.lvl = 5'd0;
        apply(v, "wrap_rst");
        for (int i = 0; i < 31; i++) begin
            v.rst_n = 1; v.rd = b2g(5'(i)); v.ack = 1;
            v.bin = 5'(i + 1); v.grey = b2g(5'(i + 1)); v.lvl = 5'd1;
            apply(v, $sformatf("wrap%0d", i));
        end
        chk("wrap.pre_grey", 32'(wr_ptr_grey), 32'h10);
        v.rd = 5'h10; v.bin = 5'h00; v.grey = 5'h00; v.lvl = 5'd1;
        apply(v, "wrap_zero");

        // Reset mid-run at bin=7 with wr_req held
        v.rst_n = 0; v.rd = 5'h00; v.ack = 0;
        v.bin = 5'h00; v.grey = 5'h00; v.lvl = 5'd0;
        apply(v, "mid_rst0");
        for (int i = 1; i <= 7; i++) begin
            v.rst_n = 1; v.ack = 1; v.bin = 5'(i); v.grey = g_tab[i]; v.lvl = 5'(i);
            apply(v, $sformatf("mid_fill%0d", i));
        end
        v.rst_n = 0; v.ack = 0; v.bin = 5'h00; v.grey = 5'h00; v.lvl = 5'd0;
        apply(v, "mid_rst");
        v.rst_n = 1; v.ack = 1; v.bin = 5'h01; v.grey = 5'h01; v.lvl = 5'd1;
        apply(v, "mid_resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
